out_channel_checker: RTL and testbench

Downstream consumer of the test program's out channel. Accepts output words one at a time over a valid/ready handshake, buffers them in a small FIFO, and compares each against an expected-value table loaded before the run. When the producer reports completion and the buffer has drained, it raises `finished` and reports pass/fail, replacing the hard-wired end-of-program comparison in each generated test.

---
 rtl/out_channel_checker.sv | 218 +++++++++++++++++++++
 tb/tb_out_channel_checker.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_channel_checker.sv
// Out-channel checker: buffers producer words in a small FIFO and compares them
// against an expected-value table, reporting pass/fail once the run has drained.

module out_channel_exp_table #(
  parameter int MemoryElementWidth = 12,
  parameter int NExpected = 16
) (
  input  logic                          clock,
  input  logic                          we,
  input  logic [$clog2(NExpected)-1:0]  wrAddr,
  input  logic [MemoryElementWidth-1:0] wrData,
  input  logic [$clog2(NExpected)-1:0]  rdAddr,
  output logic [MemoryElementWidth-1:0] rdData
);
  logic [MemoryElementWidth-1:0] entries [NExpected];

  // Deliberately not reset: the table survives a reset so a run can be repeated.
  always_ff @(posedge clock) begin
    if (we) entries[wrAddr] <= wrData;
  end

  assign rdData = entries[rdAddr];
endmodule

module out_channel_fifo #(
  parameter int DataWidth = 12,
  parameter int Depth = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 push,
  input  logic [DataWidth-1:0] pushData,
  input  logic                 pop,
  output logic [DataWidth-1:0] headData,
  output logic                 empty,
  output logic                 full
);
  localparam int PtrWidth = $clog2(Depth);
  localparam int LevelWidth = $clog2(Depth + 1);

  logic [DataWidth-1:0]  mem [Depth];
  logic [PtrWidth-1:0]   rdPtr;
  logic [PtrWidth-1:0]   wrPtr;
  logic [LevelWidth-1:0] level;
  logic                  doPush;
  logic                  doPop;

  assign empty  = (level == '0);
  assign full   = (level == LevelWidth'(Depth));
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      rdPtr <= '0;
      wrPtr <= '0;
      level <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PtrWidth'(1);
      if (doPop)  rdPtr <= rdPtr + PtrWidth'(1);
      case ({doPush, doPop})
        2'b10:   level <= level + LevelWidth'(1);
        2'b01:   level <= level - LevelWidth'(1);
        default: level <= level;
      endcase
    end
  end

  assign headData = mem[rdPtr];
endmodule

// state | meaning
// Idle  | table writable, waiting for start
// Run   | accepting and comparing words
// Drain | producer done, comparing what is still buffered
// Done  | verdict on finished/success, waiting for reset or restart
module out_channel_checker #(
  parameter int MemoryElementWidth = 12,
  parameter int NExpected = 16,
  parameter int FifoDepth = 4,
  parameter int CountWidth = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          expWe,
  input  logic [$clog2(NExpected)-1:0]  expAddr,
  input  logic [MemoryElementWidth-1:0] expData,
  input  logic [CountWidth-1:0]         expCount,
  input  logic                          start,
  input  logic                          outValid,
  input  logic [MemoryElementWidth-1:0] outData,
  output logic                          outReady,
  input  logic                          programDone,
  input  logic                          pause,
  output logic                          busy,
  output logic                          finished,
  output logic                          success,
  output logic [CountWidth-1:0]         received,
  output logic [CountWidth-1:0]         firstMismatch
);
  localparam int AddrWidth = $clog2(NExpected);

  typedef enum logic [1:0] {Idle, Run, Drain, Done} stateType;

  stateType                      state;
  stateType                      nextState;
  logic                          startRun;
  logic                          push;
  logic                          pop;
  logic                          fifoEmpty;
  logic                          fifoFull;
  logic [MemoryElementWidth-1:0] headWord;
  logic [MemoryElementWidth-1:0] expectedWord;
  logic                          inTable;
  logic                          wordBad;
  logic [CountWidth-1:0]         expCountReg;
  logic [CountWidth-1:0]         receivedReg;
  logic [CountWidth-1:0]         firstMismatchReg;
  logic                          mismatch;

  out_channel_exp_table #(
    .MemoryElementWidth(MemoryElementWidth),
    .NExpected(NExpected)
  ) expTable (
    .clock(clock),
    .we(expWe && (state == Idle)),
    .wrAddr(expAddr),
    .wrData(expData),
    .rdAddr(receivedReg[AddrWidth-1:0]),
    .rdData(expectedWord)
  );

  out_channel_fifo #(
    .DataWidth(MemoryElementWidth),
    .Depth(FifoDepth)
  ) wordFifo (
    .clock(clock),
    .reset(reset),
    .clear(startRun),
    .push(push),
    .pushData(outData),
    .pop(pop),
    .headData(headWord),
    .empty(fifoEmpty),
    .full(fifoFull)
  );

  assign push = (state == Run) && outValid && !fifoFull;
  assign pop  = ((state == Run) || (state == Drain)) && !fifoEmpty && !pause;

  // Words past expCount, or past the end of the table, can never match.
  assign inTable = int'(receivedReg) < NExpected;
  assign wordBad = (receivedReg >= expCountReg) || !inTable || (headWord != expectedWord);

  always_comb begin
    nextState = state;
    startRun  = 1'b0;
    case (state)
      Idle: begin
        if (start) begin
          startRun  = 1'b1;
          nextState = Run;
        end
      end
      Run: begin
        if (programDone) nextState = Drain;
      end
      Drain: begin
        if (fifoEmpty) nextState = Done;
      end
      Done: begin
        if (start) begin
          startRun  = 1'b1;
          nextState = Run;
        end
      end
      default: nextState = Idle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= Idle;
    else       state <= nextState;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      expCountReg      <= '0;
      receivedReg      <= '0;
      firstMismatchReg <= '1;
      mismatch         <= 1'b0;
    end else if (startRun) begin
      expCountReg      <= expCount;
      receivedReg      <= '0;
      firstMismatchReg <= '1;
      mismatch         <= 1'b0;
    end else if (pop) begin
      if (wordBad && !mismatch) begin
        firstMismatchReg <= receivedReg;
        mismatch         <= 1'b1;
      end
      if (receivedReg != '1) receivedReg <= receivedReg + CountWidth'(1);
    end
  end

  assign outReady      = (state == Run) && !fifoFull;
  assign busy          = (state == Run) || (state == Drain);
  assign finished      = (state == Done);
  assign success       = finished && !mismatch && (receivedReg == expCountReg);
  assign received      = receivedReg;
  assign firstMismatch = firstMismatchReg;
endmodule

// File: tb/tb_out_channel_checker.sv
// Bench for out_channel_checker: directed vector table, hand-written timing
// sequences, and randomized runs scored against a list-based reference model.

module tb_out_channel_checker;
  localparam int W  = 12;
  localparam int NE = 16;
  localparam int FD = 4;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          expWe = 1'b0;
  logic [3:0]    expAddr = '0;
  logic [W-1:0]  expData = '0;
  logic [CW-1:0] expCount = '0;
  logic          start = 1'b0;
  logic          outValid = 1'b0;
  logic [W-1:0]  outData = '0;
  logic          outReady;
  logic          programDone = 1'b0;
  logic          pause = 1'b0;
  logic          busy;
  logic          finished;
  logic          success;
  logic [CW-1:0] received;
  logic [CW-1:0] firstMismatch;

  int vectors = 0;
  int miscompares = 0;

  out_channel_checker #(
    .MemoryElementWidth(W),
    .NExpected(NE),
    .FifoDepth(FD),
    .CountWidth(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .expWe(expWe),
    .expAddr(expAddr),
    .expData(expData),
    .expCount(expCount),
    .start(start),
    .outValid(outValid),
    .outData(outData),
    .outReady(outReady),
    .programDone(programDone),
    .pause(pause),
    .busy(busy),
    .finished(finished),
    .success(success),
    .received(received),
    .firstMismatch(firstMismatch)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0][W-1:0] expv;
    logic [3:0]        nExp;
    logic [CW-1:0]     cnt;
    logic [7:0][W-1:0] sent;
    logic [3:0]        nSent;
    logic              expSuccess;
    logic [CW-1:0]     expReceived;
    logic [CW-1:0]     expFirst;
  } vecType;

  vecType       vecs [8];
  logic [W-1:0] tbl [NE];
  logic [W-1:0] words [$];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic doReset();
    reset = 1'b1; expWe = 1'b0; start = 1'b0; outValid = 1'b0;
    programDone = 1'b0; pause = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic loadTable(input int addr, input logic [W-1:0] d);
    expWe = 1'b1; expAddr = 4'(addr); expData = d;
    step();
    expWe = 1'b0;
  endtask

  task automatic startRun(input int cnt);
    expCount = CW'(cnt); start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic sendWord(input logic [W-1:0] d);
    int n;
    n = 0;
    outValid = 1'b1; outData = d;
    while (!outReady && n < 50) begin
      step();
      n++;
    end
    if (!outReady) check("send_timeout", outReady, 1);
    step();
    outValid = 1'b0;
  endtask

  task automatic finishRun();
    int n;
    programDone = 1'b1;
    step();
    programDone = 1'b0;
    n = 0;
    while (!finished && n < 100) begin
      step();
      n++;
    end
    check("finish_wait", finished, 1);
  endtask

  int cnt, nWords, idx, guard, acc, first, rcv, sawDone;

  initial begin
    foreach (vecs[i]) vecs[i] = '0;
    vecs[0].expv[0] = 5; vecs[0].nExp = 1; vecs[0].cnt = 1;
    vecs[0].sent[0] = 5; vecs[0].nSent = 1;
    vecs[0].expSuccess = 1; vecs[0].expReceived = 1; vecs[0].expFirst = 8'hFF;

    vecs[1].expv[0] = 5; vecs[1].expv[1] = 7; vecs[1].expv[2] = 9; vecs[1].nExp = 3; vecs[1].cnt = 3;
    vecs[1].sent[0] = 5; vecs[1].sent[1] = 8; vecs[1].sent[2] = 9; vecs[1].nSent = 3;
    vecs[1].expSuccess = 0; vecs[1].expReceived = 3; vecs[1].expFirst = 1;

    vecs[2].expv[0] = 5; vecs[2].expv[1] = 7; vecs[2].nExp = 2; vecs[2].cnt = 2;
    vecs[2].sent[0] = 5; vecs[2].nSent = 1;
    vecs[2].expSuccess = 0; vecs[2].expReceived = 1; vecs[2].expFirst = 8'hFF;

    vecs[3].expv[0] = 5; vecs[3].nExp = 1; vecs[3].cnt = 1;
    vecs[3].sent[0] = 5; vecs[3].sent[1] = 5; vecs[3].nSent = 2;
    vecs[3].expSuccess = 0; vecs[3].expReceived = 2; vecs[3].expFirst = 1;

    vecs[4].nExp = 0; vecs[4].cnt = 0; vecs[4].nSent = 0;
    vecs[4].expSuccess = 1; vecs[4].expReceived = 0; vecs[4].expFirst = 8'hFF;

    vecs[5].expv[0] = 1; vecs[5].expv[1] = 2; vecs[5].expv[2] = 3; vecs[5].expv[3] = 4;
    vecs[5].nExp = 4; vecs[5].cnt = 4;
    vecs[5].sent[0] = 1; vecs[5].sent[1] = 2; vecs[5].sent[2] = 3; vecs[5].sent[3] = 4;
    vecs[5].nSent = 4;
    vecs[5].expSuccess = 1; vecs[5].expReceived = 4; vecs[5].expFirst = 8'hFF;

    vecs[6].expv[0] = 12'hA; vecs[6].expv[1] = 12'hB; vecs[6].nExp = 2; vecs[6].cnt = 2;
    vecs[6].sent[0] = 12'hA; vecs[6].sent[1] = 12'hC; vecs[6].sent[2] = 12'hD; vecs[6].nSent = 3;
    vecs[6].expSuccess = 0; vecs[6].expReceived = 3; vecs[6].expFirst = 1;

    vecs[7].expv[0] = 7; vecs[7].expv[1] = 7; vecs[7].nExp = 2; vecs[7].cnt = 2;
    vecs[7].sent[0] = 6; vecs[7].sent[1] = 7; vecs[7].nSent = 2;
    vecs[7].expSuccess = 0; vecs[7].expReceived = 2; vecs[7].expFirst = 0;

    // Reset state
    reset = 1'b1;
    step();
    check("rst_outReady", outReady, 0);
    check("rst_busy", busy, 0);
    check("rst_finished", finished, 0);
    check("rst_success", success, 0);
    check("rst_received", received, 0);
    check("rst_firstMismatch", firstMismatch, 255);
    reset = 1'b0;

    // Directed vector table
    for (int v = 0; v < 8; v++) begin
      doReset();
      for (int i = 0; i < int'(vecs[v].nExp); i++) loadTable(i, vecs[v].expv[i]);
      startRun(int'(vecs[v].cnt));
      for (int i = 0; i < int'(vecs[v].nSent); i++) sendWord(vecs[v].sent[i]);
      finishRun();
      check($sformatf("vec%0d_success", v), success, vecs[v].expSuccess);
      check($sformatf("vec%0d_received", v), received, vecs[v].expReceived);
      check($sformatf("vec%0d_firstMismatch", v), firstMismatch, vecs[v].expFirst);
    end

    // Start, latency and completion timing; programDone ignored in IDLE
    doReset();
    loadTable(0, 12'd33);
    programDone = 1'b1;
    step();
    programDone = 1'b0;
    check("idle_done_ignored", busy, 0);
    startRun(1);
    check("start_busy", busy, 1);
    check("start_ready", outReady, 1);
    outValid = 1'b1; outData = 12'd33;
    step();
    outValid = 1'b0;
    check("lat_after_accept", received, 0);
    step();
    check("lat_after_pop", received, 1);
    programDone = 1'b1;
    step();
    programDone = 1'b0;
    check("drain_busy", busy, 1);
    check("drain_not_finished", finished, 0);
    step();
    check("done_finished", finished, 1);
    check("done_success", success, 1);

    // Table write ignored in DONE; restart from DONE clears the verdict
    loadTable(0, 12'd99);
    startRun(1);
    check("restart_finished", finished, 0);
    check("restart_success", success, 0);
    check("restart_received", received, 0);
    sendWord(12'd33);
    finishRun();
    check("restart_table_kept", success, 1);

    // Backpressure with pause
    doReset();
    for (int i = 0; i < 6; i++) loadTable(i, W'(10 + i));
    startRun(6);
    pause = 1'b1; outValid = 1'b1; acc = 0;
    for (int c = 0; c < 8; c++) begin
      outData = W'(10 + acc);
      if (outReady) acc++;
      step();
    end
    check("pause_accepted", acc, 4);
    check("pause_ready_low", outReady, 0);
    check("pause_received", received, 0);
    pause = 1'b0;
    step();
    check("unpause_ready", outReady, 1);
    guard = 0;
    while (acc < 6 && guard < 50) begin
      outData = W'(10 + acc);
      if (outReady) acc++;
      step();
      guard++;
    end
    outValid = 1'b0;
    check("unpause_accepted", acc, 6);
    finishRun();
    check("pause_success", success, 1);
    check("pause_received_all", received, 6);

    // Reset mid-run, then rerun with the table untouched
    doReset();
    loadTable(0, 12'h101); loadTable(1, 12'h202); loadTable(2, 12'h303);
    startRun(3);
    sendWord(12'h101);
    sendWord(12'h202);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_ready", outReady, 0);
    check("midrst_finished", finished, 0);
    check("midrst_success", success, 0);
    check("midrst_received", received, 0);
    check("midrst_firstMismatch", firstMismatch, 255);
    startRun(3);
    sendWord(12'h101);
    sendWord(12'h202);
    sendWord(12'h303);
    finishRun();
    check("midrst_rerun_success", success, 1);

    // Randomized runs against the list-based model
    for (int r = 0; r < 30; r++) begin
      doReset();
      for (int i = 0; i < NE; i++) begin
        tbl[i] = W'($urandom_range(0, 4095));
        loadTable(i, tbl[i]);
      end
      cnt = $urandom_range(0, 10);
      nWords = $urandom_range(0, 12);
      words.delete();
      for (int i = 0; i < nWords; i++)
        words.push_back(($urandom % 5 != 0) ? tbl[i] : W'($urandom));
      startRun(cnt);
      idx = 0; guard = 0; sawDone = 0;
      while (idx < nWords && guard < 400) begin
        pause = ($urandom % 3 == 0);
        outValid = ($urandom % 4 != 0);
        outData = words[idx];
        if (outValid && outReady) begin
          idx++;
          if (idx == nWords && $urandom % 2 == 1) begin
            programDone = 1'b1;
            sawDone = 1;
          end
        end
        step();
        programDone = 1'b0;
        guard++;
      end
      outValid = 1'b0;
      check($sformatf("rand%0d_fed", r), idx, nWords);
      if (sawDone == 0) begin
        programDone = 1'b1;
        step();
        programDone = 1'b0;
      end
      guard = 0;
      while (!finished && guard < 400) begin
        pause = ($urandom % 3 == 0);
        step();
        guard++;
      end
      pause = 1'b0;
      check($sformatf("rand%0d_finished", r), finished, 1);

      rcv = (nWords > 255) ? 255 : nWords;
      first = 255;
      for (int i = 0; i < nWords; i++)
        if (first == 255 && (i >= cnt || i >= NE || words[i] != tbl[i])) first = i;
      check($sformatf("rand%0d_received", r), received, rcv);
      check($sformatf("rand%0d_firstMismatch", r), firstMismatch, first);
      check($sformatf("rand%0d_success", r), success, (first == 255 && nWords == cnt) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end
endmodule
